keypad_scanner: RTL and testbench

- Drives the row lines of the 4x3 whack-a-mole keypad and reads its active-low column lines.
- Walks one active-low row at a time and samples the columns on that row.
- Debounces press and release while the row is held.
- Reports each debounced press as a key code with a one-cycle valid strobe.
- Sits between the keypad pins and the game logic. Fully replaces column-only key detection with row/column decode.

---
 rtl/keypad_scanner_pkg.sv | 16 +
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner_col_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 159 +++++++++++++++
 tb/tb_keypad_scanner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM encoding, geometry and
// board clock used to size the default debounce window.
package keypad_scanner_pkg;

   localparam int ROWS       = 4;
   localparam int COLS       = 3;
   localparam int KEY_CODE_W = 4;
   localparam int CLK_HZ     = 50_000_000;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the decoded key outputs handed to the game logic.
interface keypad_scanner_if
   import keypad_scanner_pkg::*;
#(
   parameter int ROWS = keypad_scanner_pkg::ROWS,
   parameter int COLS = keypad_scanner_pkg::COLS
);

   logic [ROWS-1:0]       row;
   logic [COLS-1:0]       column;
   logic [KEY_CODE_W-1:0] key_code;
   logic                  key_valid;
   logic                  key_held;

   modport master (
      output row,
      input  column,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      input  row,
      output column,
      input  key_code,
      input  key_valid,
      input  key_held
   );

endinterface

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous column pins; resets to the
// released (all ones) level so no phantom press is seen after reset.
module keypad_scanner_col_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] col_p0;
   logic [W-1:0] col_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         col_p0 <= '1;
         col_p1 <= '1;
      end else begin
         col_p0 <= d;
         col_p1 <= col_p0;
      end
   end

   assign q = col_p1;

endmodule

// File: rtl/keypad_scanner.sv
// Row-walking keypad scanner: drives one active-low row at a time, debounces
// press and release on that row, and reports each accepted key once.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int ROWS           = keypad_scanner_pkg::ROWS,
   parameter int COLS           = keypad_scanner_pkg::COLS,
   parameter int SETTLE_CYCLES  = 4,
   parameter int DEBOUNCE_COUNT = CLK_HZ / 1000
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master bus
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SET_W = $clog2(SETTLE_CYCLES);
   localparam int CNT_W = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

   if (ROWS * COLS > 16 || SETTLE_CYCLES < 3 || DEBOUNCE_COUNT < 2) begin : g_bad_params
      $error("keypad_scanner: unsupported ROWS/COLS/SETTLE_CYCLES/DEBOUNCE_COUNT");
   end

   function automatic logic [ROW_W-1:0] next_row(logic [ROW_W-1:0] r);
      return (r == ROW_LAST) ? '0 : r + 1'b1;
   endfunction

   // Scan from the top so the last hit wins: that is the lowest low column.
   function automatic logic [COL_W-1:0] lowest_low(logic [COLS-1:0] c);
      logic [COL_W-1:0] idx;
      idx = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (!c[i]) idx = COL_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [KEY_CODE_W-1:0] key_of(logic [ROW_W-1:0] r, logic [COL_W-1:0] c);
      return KEY_CODE_W'(r) * KEY_CODE_W'(COLS) + KEY_CODE_W'(c);
   endfunction

   logic [COLS-1:0] col_s;

   keypad_scanner_col_sync #(.W(COLS)) u_col_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.column),
      .q     (col_s)
   );

   state_t                state_q,   state_n;
   logic [ROW_W-1:0]      row_idx_q, row_idx_n;
   logic [COL_W-1:0]      col_idx_q, col_idx_n;
   logic [SET_W-1:0]      settle_q,  settle_n;
   logic [CNT_W-1:0]      stable_q,  stable_n;
   logic [CNT_W-1:0]      rel_q,     rel_n;
   logic [KEY_CODE_W-1:0] code_q,    code_n;
   logic                  valid_q,   valid_n;
   logic                  held_q,    held_n;
   logic                  run_q;
   logic                  col_bit;

   assign col_bit = col_s[col_idx_q];

   // run_q keeps the rows released for the cycle reset is still asserted
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SCAN;
         row_idx_q <= '0;
         col_idx_q <= '0;
         settle_q  <= '0;
         stable_q  <= '0;
         rel_q     <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         row_idx_q <= row_idx_n;
         col_idx_q <= col_idx_n;
         settle_q  <= settle_n;
         stable_q  <= stable_n;
         rel_q     <= rel_n;
         code_q    <= code_n;
         valid_q   <= valid_n;
         held_q    <= held_n;
         run_q     <= 1'b1;
      end
   end

   always_comb begin
      state_n   = state_q;
      row_idx_n = row_idx_q;
      col_idx_n = col_idx_q;
      settle_n  = settle_q;
      stable_n  = stable_q;
      rel_n     = rel_q;
      code_n    = code_q;
      valid_n   = 1'b0;
      held_n    = held_q;
      if (run_q) begin
         case (state_q)
            SCAN: begin
               if (settle_q != SET_LAST) begin
                  settle_n = settle_q + 1'b1;
               end else begin
                  settle_n = '0;
                  if (&col_s) begin
                     row_idx_n = next_row(row_idx_q);
                  end else begin
                     col_idx_n = lowest_low(col_s);
                     stable_n  = '0;
                     state_n   = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (col_bit) begin
                  settle_n = '0;
                  state_n  = SCAN;
               end else if (stable_q == CNT_LAST) begin
                  code_n  = key_of(row_idx_q, col_idx_q);
                  valid_n = 1'b1;
                  held_n  = 1'b1;
                  rel_n   = '0;
                  state_n = HELD;
               end else begin
                  stable_n = stable_q + 1'b1;
               end
            end
            HELD: begin
               if (!col_bit) begin
                  rel_n = '0;
               end else if (rel_q == CNT_LAST) begin
                  held_n    = 1'b0;
                  row_idx_n = next_row(row_idx_q);
                  settle_n  = '0;
                  state_n   = SCAN;
               end else begin
                  rel_n = rel_q + 1'b1;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   assign bus.row       = run_q ? ~(ROWS'(1) << row_idx_q) : '1;
   assign bus.key_code  = code_q;
   assign bus.key_valid = valid_q;
   assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a keypad matrix
// model and key-event expectations derived from scan/debounce timing rules.
module tb_keypad_scanner;
   import keypad_scanner_pkg::*;

   localparam int NR      = 4;
   localparam int NC      = 3;
   localparam int SETTLE  = 4;
   localparam int DB      = 8;
   localparam int LAT_MAX = 2 + NR * SETTLE + DB;
   localparam int REL_LAT = 2 + DB;

   logic clk;
   logic reset;
   logic [NR*NC-1:0] keys;
   logic [NC-1:0] col_model;

   int total;
   int bad;
   int pulse_cnt;
   logic [3:0] last_pulse_code;

   keypad_scanner_if #(.ROWS(NR), .COLS(NC)) bus ();

   keypad_scanner #(
      .ROWS           (NR),
      .COLS           (NC),
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_COUNT (DB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive key matrix: a closed key pulls its column low while its row is driven low.
   always_comb begin
      col_model = '1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (keys[r*NC+c] && bus.row[r] === 1'b0) col_model[c] = 1'b0;
   end
   assign bus.column = col_model;

   always @(negedge clk) begin
      if (bus.key_valid === 1'b1) begin
         pulse_cnt       <= pulse_cnt + 1;
         last_pulse_code <= bus.key_code;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   function automatic logic [3:0] row_of(input int r);
      logic [3:0] e;
      e = 4'b1111;
      e[r] = 1'b0;
      return e;
   endfunction

   task automatic wait_valid(input int limit, output int lat);
      lat = -1;
      for (int i = 1; i <= limit && lat < 0; i++) begin
         tick();
         if (bus.key_valid === 1'b1) lat = i;
      end
   endtask

   task automatic press_check(input int k, input int limit, input string tag);
      int lat;
      keys[k] = 1'b1;
      wait_valid(limit, lat);
      check({tag, "_found"}, (lat >= 1) ? 1 : 0, 1);
      check({tag, "_code"}, bus.key_code, k);
      check({tag, "_held"}, bus.key_held, 1);
   endtask

   task automatic release_check(input int k, input string tag);
      int n;
      keys[k] = 1'b0;
      n = -1;
      for (int i = 1; i <= 4 * REL_LAT && n < 0; i++) begin
         tick();
         if (bus.key_held === 1'b0) n = i;
      end
      check({tag, "_release_lat"}, n, REL_LAT);
   endtask

   initial begin
      int p0;
      int row_bad;
      int k;
      int h;
      int lat;
      logic [3:0] exp_code;

      total = 0;
      bad = 0;
      pulse_cnt = 0;
      last_pulse_code = '0;
      keys = '0;
      reset = 1'b1;

      // Reset state
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_row", bus.row, 4'b1111);
         check("rst_code", bus.key_code, 0);
         check("rst_valid", bus.key_valid, 0);
         check("rst_held", bus.key_held, 0);
      end

      // Idle walk: each row low for SETTLE cycles in turn
      reset = 1'b0;
      tick();
      row_bad = 0;
      for (int t = 0; t < 8 * SETTLE; t++) begin
         if (bus.row !== row_of((t / SETTLE) % NR) || bus.key_valid !== 1'b0) row_bad++;
         tick();
      end
      check("idle_walk", row_bad, 0);
      check("idle_pulses", pulse_cnt, 0);

      // Key 7: row 2, column 1
      p0 = pulse_cnt;
      press_check(7, LAT_MAX, "key7");
      row_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.row !== row_of(2)) row_bad++;
      end
      check("key7_row_hold", row_bad, 0);
      release_check(7, "key7");
      ticks(4);
      check("key7_pulses", pulse_cnt - p0, 1);
      exp_code = 4'd7;

      // Bounce on key 0, then settle low
      p0 = pulse_cnt;
      for (int i = 0; i < 40; i++) begin
         keys[0] = ((i / 3) % 2 == 0);
         tick();
      end
      check("bounce_no_pulse", pulse_cnt - p0, 0);
      check("bounce_code_kept", bus.key_code, exp_code);
      press_check(0, LAT_MAX, "bounce");
      release_check(0, "bounce");
      ticks(4);
      check("bounce_pulses", pulse_cnt - p0, 1);
      exp_code = 4'd0;

      // Two keys on row 1 resolve to the lowest column
      p0 = pulse_cnt;
      keys[5] = 1'b1;
      press_check(3, LAT_MAX, "multi");
      keys[5] = 1'b0;
      ticks(50);
      check("multi_no_repulse", pulse_cnt - p0, 1);
      check("multi_still_held", bus.key_held, 1);
      release_check(3, "multi");
      exp_code = 4'd3;

      // Reset while key 11 is held
      press_check(11, LAT_MAX, "k11");
      reset = 1'b1;
      tick();
      check("midrst_row", bus.row, 4'b1111);
      check("midrst_code", bus.key_code, 0);
      check("midrst_valid", bus.key_valid, 0);
      check("midrst_held", bus.key_held, 0);
      reset = 1'b0;
      wait_valid(LAT_MAX + 4, lat);
      check("k11_redetect", (lat >= 1) ? 1 : 0, 1);
      check("k11_recode", bus.key_code, 11);
      release_check(11, "k11");
      exp_code = 4'd11;

      // Long hold of key 5
      p0 = pulse_cnt;
      press_check(5, LAT_MAX, "key5");
      row_bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.row !== 4'b1101 || bus.key_held !== 1'b1) row_bad++;
      end
      check("key5_row_hold", row_bad, 0);
      release_check(5, "key5");
      ticks(4);
      check("key5_pulses", pulse_cnt - p0, 1);
      exp_code = 4'd5;

      // Random long presses (reported once) and glitches too short to accept
      for (int trial = 0; trial < 12; trial++) begin
         k = $urandom_range(0, NR * NC - 1);
         p0 = pulse_cnt;
         if ($urandom_range(0, 1) == 1) begin
            press_check(k, LAT_MAX, "rnd_long");
            h = $urandom_range(10, 40);
            row_bad = 0;
            for (int i = 0; i < h; i++) begin
               tick();
               if (bus.row !== row_of(k / NC)) row_bad++;
            end
            check("rnd_row_hold", row_bad, 0);
            release_check(k, "rnd_long");
            ticks(4);
            check("rnd_long_pulses", pulse_cnt - p0, 1);
            check("rnd_long_last", last_pulse_code, k);
            exp_code = 4'(k);
         end else begin
            h = $urandom_range(1, 5);
            keys[k] = 1'b1;
            ticks(h);
            keys[k] = 1'b0;
            ticks(LAT_MAX + 10);
            check("rnd_short_pulses", pulse_cnt - p0, 0);
            check("rnd_short_code", bus.key_code, exp_code);
            check("rnd_short_held", bus.key_held, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
